// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an sfifo read port: pops one word when the FIFO is non-empty
// and cts is high, then sends it LSB-first with start/stop bits. Optional even parity: UART_TX_PARITY_EN.
module uart_tx_drain #(
    parameter int WIDTH    = 8,
    parameter int CLKDIV   = 16,
    parameter int STOPBITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_read,
    input  logic             cts,
    output logic             txd,
    output logic             busy
);

    localparam int TW = $clog2(CLKDIV);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TMAX  = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] TZERO = TW'(0);
    localparam logic [TW-1:0] TONE  = TW'(1);
    localparam logic [BW-1:0] BZERO = BW'(0);
    localparam logic [BW-1:0] BONE  = BW'(1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] SLAST = BW'(STOPBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [BW-1:0]    r_bitcnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_txd;
    logic             r_read;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [BW-1:0]    w_bitcnt_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_txd_nxt;
    logic             w_read_nxt;
    logic             w_tick;

`ifdef UART_TX_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign w_tick = (r_timer == TZERO);

    // Next-state and datapath decode; everything lands in registers below.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_txd_nxt    = r_txd;
        w_read_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty && cts) begin
                    w_state_nxt = S_FETCH;
                    w_read_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                // rdata became valid on the FETCH edge, so it is stable here
                w_shift_nxt = fifo_rdata;
                w_txd_nxt   = 1'b0;
                w_timer_nxt = TMAX;
                w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                w_parity_nxt = even_parity(fifo_rdata);
`endif
            end
            S_START: begin
                if (w_tick) begin
                    w_txd_nxt    = r_shift[0];
                    w_timer_nxt  = TMAX;
                    w_bitcnt_nxt = BZERO;
                    w_state_nxt  = S_DATA;
                end else begin
                    w_timer_nxt = r_timer - TONE;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_timer_nxt = TMAX;
                    if (r_bitcnt == BLAST) begin
                        w_bitcnt_nxt = BZERO;
`ifdef UART_TX_PARITY_EN
                        w_txd_nxt   = r_parity;
                        w_state_nxt = S_PARITY;
`else
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_shift_nxt  = r_shift >> 1;
                        w_txd_nxt    = w_shift_nxt[0];
                        w_bitcnt_nxt = r_bitcnt + BONE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_timer_nxt  = TMAX;
                    w_txd_nxt    = 1'b1;
                    w_bitcnt_nxt = BZERO;
                    w_state_nxt  = S_STOP;
                end else begin
                    w_timer_nxt = r_timer - TONE;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_bitcnt == SLAST) begin
                        // timer parks at zero in IDLE rather than reloading
                        w_bitcnt_nxt = BZERO;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BONE;
                        w_timer_nxt  = TMAX;
                    end
                end else begin
                    w_timer_nxt = r_timer - TONE;
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_timer  <= TZERO;
            r_bitcnt <= BZERO;
            r_shift  <= {WIDTH{1'b0}};
            r_txd    <= 1'b1;
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_txd    <= w_txd_nxt;
            r_read   <= w_read_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign fifo_read = r_read;
    assign txd       = r_txd;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a behavioural FIFO in front of it.
// Frame shape follows UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_drain;

    localparam int CLKDIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLKDIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_read;
    logic       cts;
    logic       txd;
    logic       busy;

    logic       push_v;
    logic [7:0] push_d;
    logic [7:0] q[$];

    int cyc = 0;
    int nreads = 0;
    int last_rd_cyc = -100;
    int pops = 0;
    int underflow = 0;
    int n_checks = 0;
    int n_fail = 0;

    uart_tx_drain #(.WIDTH(8), .CLKDIV(CLKDIV), .STOPBITS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_read  (fifo_read),
        .cts        (cts),
        .txd        (txd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pop on read (rdata valid next cycle), push from stimulus, registered empty.
    always @(posedge clk) begin
        if (fifo_read === 1'b1) begin
            if (q.size() > 0) begin
                fifo_rdata <= q[0];
                q.delete(0);
                pops <= pops + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
        if (push_v) q.push_back(push_d);
        fifo_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_read === 1'b1) begin
            nreads = nreads + 1;
            last_rd_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] d);
        push_v = 1'b1;
        push_d = d;
        @(negedge clk);
        push_v = 1'b0;
    endtask

    task automatic get_frame(input logic [7:0] d, input string nm, output int fall_cyc);
        int t;
        int err;
        logic [10:0] eb;
        logic [7:0] dec;
        eb = frame_bits(d);
        t = 0;
        err = 0;
        dec = 8'h00;
        fall_cyc = -1;
        while (txd !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (txd !== 1'b0) begin
            $display("FAIL %s_start: txd stayed %b for %0d cycles, required 0", nm, txd, t);
            n_fail++;
            return;
        end
        fall_cyc = cyc;
        n_checks++;
        if (fall_cyc - last_rd_cyc !== 2) begin
            $display("FAIL %s_latency: read-to-start %0d cycles, required 2", nm, fall_cyc - last_rd_cyc);
            n_fail++;
        end
        for (int k = 0; k < FRAME; k++) begin
            if (txd !== eb[k / CLKDIV] || busy !== 1'b1) err++;
            if ((k % CLKDIV) == 2 && k >= CLKDIV && k < 9 * CLKDIV) dec[(k - CLKDIV) / CLKDIV] = txd;
            @(negedge clk);
        end
        n_checks++;
        if (err != 0) begin
            $display("FAIL %s_bits: %0d bad cycles in frame, required 0 (expected bits %b)", nm, err, eb);
            n_fail++;
        end
        n_checks++;
        if (dec !== d) begin
            $display("FAIL %s_data: decoded %h, required %h", nm, dec, d);
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            $display("FAIL %s_end: busy=%b txd=%b after %0d cycles, required busy=0 txd=1", nm, busy, txd, FRAME);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        int err;
        err = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin $display("FAIL rst_txd: got %b, required 1", txd); n_fail++; end
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b, required 0", busy); n_fail++; end
        n_checks++;
        if (fifo_read !== 1'b0) begin $display("FAIL rst_read: got %b, required 0", fifo_read); n_fail++; end
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) err++;
        end
        n_checks++;
        if (err != 0 || nreads != 0) begin
            $display("FAIL idle_empty: %0d bad cycles, %0d reads, required 0 and 0", err, nreads);
            n_fail++;
        end
    endtask

    task automatic test_single();
        int n0;
        int f;
        n0 = nreads;
        push(8'hA5);
        get_frame(8'hA5, "single", f);
        repeat (10) @(negedge clk);
        n_checks++;
        if (nreads != n0 + 1 || busy !== 1'b0) begin
            $display("FAIL single_reads: %0d reads busy=%b, required 1 and 0", nreads - n0, busy);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int f1;
        int f2;
        int f3;
        n0 = nreads;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        get_frame(8'h12, "burst0", f1);
        get_frame(8'h34, "burst1", f2);
        get_frame(8'h56, "burst2", f3);
        n_checks++;
        if (f2 - f1 != FRAME + 3) begin
            $display("FAIL burst_gap1: start spacing %0d, required %0d", f2 - f1, FRAME + 3);
            n_fail++;
        end
        n_checks++;
        if (f3 - f2 != FRAME + 3) begin
            $display("FAIL burst_gap2: start spacing %0d, required %0d", f3 - f2, FRAME + 3);
            n_fail++;
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (nreads != n0 + 3 || fifo_empty !== 1'b1) begin
            $display("FAIL burst_reads: %0d reads empty=%b, required 3 and 1", nreads - n0, fifo_empty);
            n_fail++;
        end
    endtask

    task automatic test_flow();
        int n0;
        int f;
        int err;
        err = 0;
        n0 = nreads;
        cts = 1'b0;
        push(8'h3C);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) err++;
        end
        n_checks++;
        if (nreads != n0 || err != 0) begin
            $display("FAIL cts_hold: %0d reads %0d bad cycles, required 0 and 0", nreads - n0, err);
            n_fail++;
        end
        cts = 1'b1;
        fork
            get_frame(8'h3C, "flow", f);
            begin
                repeat (30) @(negedge clk);
                cts = 1'b0;
            end
        join
        cts = 1'b1;
        n_checks++;
        if (nreads != n0 + 1) begin
            $display("FAIL flow_reads: %0d reads, required 1", nreads - n0);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int p0;
        int t;
        int err;
        n0 = nreads;
        p0 = pops;
        t = 0;
        err = 0;
        push(8'hFF);
        while (txd !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        // data bit 3 spans cycles 16..19 after the start-bit edge
        repeat (17) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) begin
            $display("FAIL midrst_edge: txd=%b busy=%b read=%b, required 1 0 0", txd, busy, fifo_read);
            n_fail++;
        end
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) err++;
        end
        n_checks++;
        if (err != 0 || nreads != n0 + 1 || pops != p0 + 1) begin
            $display("FAIL midrst_after: %0d bad cycles %0d reads %0d pops, required 0 1 1", err, nreads - n0, pops - p0);
            n_fail++;
        end
    endtask

    task automatic test_parity();
        int f;
        push(8'h07);
        get_frame(8'h07, "par07", f);
        push(8'h03);
        get_frame(8'h03, "par03", f);
        n_checks++;
        if (underflow != 0) begin
            $display("FAIL no_empty_read: %0d reads of an empty FIFO, required 0", underflow);
            n_fail++;
        end
    endtask

    initial begin
        reset  = 1'b0;
        cts    = 1'b1;
        push_v = 1'b0;
        push_d = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_flow();
        test_reset_mid();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
